// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 8-bit, 4-opcode CPU: opcode
//               encodings, controller state encodings and instruction
//               field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes (instruction[7:6])
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_LW  = 2'b01;
    localparam logic [1:0] c_OP_SW  = 2'b10;
    localparam logic [1:0] c_OP_J   = 2'b11;

    // Controller state encodings; the numeric values are visible on the
    // state output, so they must not be reordered.
    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_MEM    = 3'd4;
    localparam logic [2:0] c_ST_WB     = 3'd5;

    // Instruction field positions
    localparam int c_OP_MSB  = 7;
    localparam int c_OP_LSB  = 6;
    localparam int c_RS_MSB  = 5;
    localparam int c_RS_LSB  = 4;
    localparam int c_RT_MSB  = 3;
    localparam int c_RT_LSB  = 2;
    localparam int c_RD_MSB  = 1;
    localparam int c_RD_LSB  = 0;

    function automatic logic [1:0] get_op(input logic [7:0] instr);
        return instr[c_OP_MSB:c_OP_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_tick_gen
// Description : Execution pacing for the multicycle controller.
//               - Free-running divider producing a one-cycle tick every
//                 STEP_DIV clocks (tick on count STEP_DIV-1).
//               - Rising-edge detector on the step level, holding at most
//                 one pending single-step request until consumed.
// Ports       : i_clk50        system clock
//               i_reset        asynchronous active-high reset
//               i_step         single-step level (synchronous)
//               i_consume      controller is starting an instruction now
//               o_tick         one-cycle pacing pulse
//               o_step_pending a single-step request is waiting
// Revision    : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
    parameter int STEP_DIV = 25000000
) (
    input  logic i_clk50,
    input  logic i_reset,
    input  logic i_step,
    input  logic i_consume,
    output logic o_tick,
    output logic o_step_pending
);

    localparam int                 c_DIV_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_step_q;
    logic               r_pending;
    logic               w_step_rise;

    // Divider runs regardless of what the controller is doing.
    always_ff @(posedge i_clk50 or posedge i_reset) begin
        if (i_reset) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_tick      = (r_div == c_DIV_LAST);
    assign w_step_rise = i_step & ~r_step_q;

    // A held request absorbs any further edges. When the request is being
    // consumed this cycle, a simultaneous edge is only kept if it is not the
    // one already being serviced (i.e. when the start came from the tick).
    always_ff @(posedge i_clk50 or posedge i_reset) begin
        if (i_reset) begin
            r_step_q  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_step_q <= i_step;
            if (i_consume) begin
                r_pending <= w_step_rise & ~r_pending;
            end else begin
                r_pending <= r_pending | w_step_rise;
            end
        end
    end

    assign o_step_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle sequencing controller for the 8-bit CPU datapath.
//               Starts one instruction per pacing tick (run=1) or per
//               single-step edge, walks FETCH/DECODE/EXEC/MEM/WB according
//               to the latched opcode and drives Moore datapath enables.
// Ports       : clk50        system clock
//               reset        asynchronous active-high reset
//               run          free-run enable (one instruction per tick)
//               step         single-step level; each rising edge = 1 instr
//               instruction  ROM data at the current PC
//               ir_write, pc_write, pc_src, alu_src, mem_read, mem_write,
//               reg_write, reg_dst   datapath control enables
//               state        current state encoding
//               halted       idle and not free-running
//               instr_count  retired-instruction counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int STEP_DIV = 25000000,
    parameter int CNT_W    = 8
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [7:0]       instruction,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [1:0]           r_op;
    logic [CNT_W-1:0]     r_instr_count;
    logic                 w_tick;
    logic                 w_step_pending;
    logic                 w_start;
    logic                 w_consume;
    logic                 w_retire;
    // Operand fields are consumed by the datapath, not by the controller.
    logic [5:0]           w_operands_unused;

    assign w_operands_unused = instruction[c_RS_MSB:c_RD_LSB];

    assign w_start   = (run & w_tick) | w_step_pending;
    assign w_consume = (r_state == c_ST_IDLE) & w_start;

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick_gen (
        .i_clk50        (clk50),
        .i_reset        (reset),
        .i_step         (step),
        .i_consume      (w_consume),
        .o_tick         (w_tick),
        .o_step_pending (w_step_pending)
    );

    // ------------------------------------------------------------------
    // State register, opcode latch and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_op          <= c_OP_ADD;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            // FETCH always lasts exactly one cycle, so this is the edge
            // leaving FETCH; later decisions never look at the live ROM.
            if (r_state == c_ST_FETCH) begin
                r_op <= get_op(instruction);
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_FETCH:  w_next_state = c_ST_DECODE;
            c_ST_DECODE: w_next_state = c_ST_EXEC;
            c_ST_EXEC: begin
                case (r_op)
                    c_OP_J:   w_next_state = c_ST_IDLE;
                    c_OP_ADD: w_next_state = c_ST_WB;
                    default:  w_next_state = c_ST_MEM;
                endcase
            end
            c_ST_MEM: begin
                if (r_op == c_OP_LW) begin
                    w_next_state = c_ST_WB;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_WB:  w_next_state = c_ST_IDLE;
            default:  w_next_state = c_ST_IDLE;
        endcase
    end

    assign w_retire = (w_next_state == c_ST_IDLE) &&
                      ((r_state == c_ST_EXEC) || (r_state == c_ST_MEM) ||
                       (r_state == c_ST_WB));

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            c_ST_EXEC: begin
                alu_src = (r_op == c_OP_LW) || (r_op == c_OP_SW);
                if (r_op == c_OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            c_ST_MEM: begin
                mem_read  = (r_op == c_OP_LW);
                mem_write = (r_op == c_OP_SW);
            end
            c_ST_WB: begin
                reg_write = 1'b1;
                reg_dst   = (r_op == c_OP_ADD);
            end
            default: ;
        endcase
    end

    assign state       = r_state;
    assign halted      = (r_state == c_ST_IDLE) & ~run;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl (STEP_DIV=4).
//               Each started instruction pushes its expected per-cycle
//               state/enable trace and its expected retire count; a
//               negedge monitor pops and compares as the controller runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    localparam int STEP_DIV = 4;
    localparam int CNT_W    = 8;

    logic             clk50 = 1'b0;
    logic             reset;
    logic             run;
    logic             step;
    logic [7:0]       instruction;
    logic             ir_write, pc_write, pc_src, alu_src;
    logic             mem_read, mem_write, reg_write, reg_dst;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc      = 0;
    logic [10:0]      exp_q[$];
    logic [7:0]       cnt_q[$];
    logic [7:0]       exp_cnt  = 8'd0;
    bit               mon_en   = 1'b0;
    bit               was_busy = 1'b0;

    multicycle_ctrl #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk50       (clk50),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .instruction (instruction),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src     (alu_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .state       (state),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #10 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // {state, ir_write, pc_write, pc_src, alu_src, mem_read, mem_write, reg_write, reg_dst}
    function automatic logic [10:0] exp_word(input logic [2:0] st, input logic [1:0] op);
        logic [7:0] en;
        en = 8'b0;
        if (st == c_ST_FETCH) en = 8'b1100_0000;
        if (st == c_ST_EXEC) begin
            if (op == c_OP_LW || op == c_OP_SW) en = 8'b0001_0000;
            if (op == c_OP_J)                   en = 8'b0110_0000;
        end
        if (st == c_ST_MEM) begin
            if (op == c_OP_LW) en = 8'b0000_1000;
            if (op == c_OP_SW) en = 8'b0000_0100;
        end
        if (st == c_ST_WB) en = (op == c_OP_ADD) ? 8'b0000_0011 : 8'b0000_0010;
        return {st, en};
    endfunction

    task automatic push_instr(input logic [7:0] instr);
        logic [1:0] op;
        op = instr[7:6];
        exp_q.push_back(exp_word(c_ST_FETCH, op));
        exp_q.push_back(exp_word(c_ST_DECODE, op));
        exp_q.push_back(exp_word(c_ST_EXEC, op));
        if (op == c_OP_LW || op == c_OP_SW) exp_q.push_back(exp_word(c_ST_MEM, op));
        if (op == c_OP_LW || op == c_OP_ADD) exp_q.push_back(exp_word(c_ST_WB, op));
        exp_cnt = exp_cnt + 8'd1;
        cnt_q.push_back(exp_cnt);
    endtask

    always @(negedge clk50) begin
        if (mon_en) begin
            if (state != c_ST_IDLE) begin
                if (exp_q.size() == 0) check_eq("unexpected_busy", {29'd0, state}, 32'd0);
                else check_eq("trace", {state, ir_write, pc_write, pc_src, alu_src,
                                        mem_read, mem_write, reg_write, reg_dst}, exp_q.pop_front());
            end else begin
                check_eq("idle_enables", {ir_write, pc_write, pc_src, alu_src,
                                          mem_read, mem_write, reg_write, reg_dst}, 32'd0);
                check_eq("halted", halted, !run);
                if (was_busy && cnt_q.size() != 0) check_eq("instr_count", instr_count, cnt_q.pop_front());
            end
            was_busy = (state != c_ST_IDLE);
        end
    end

    task automatic wait_retired(input logic [7:0] target, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk50);
            if (state == c_ST_IDLE && instr_count == target && exp_q.size() == 0) done = 1'b1;
        end
        check_eq("retire_wait", done, 1);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk50);
            if (state == st) done = 1'b1;
        end
        check_eq("state_wait", done, 1);
    endtask

    task automatic step_instr(input logic [7:0] instr);
        @(posedge clk50); #1;
        instruction = instr;
        step        = 1'b1;
        @(posedge clk50); #1;
        step        = 1'b0;
    endtask

    // Free-run n instructions; run drops in the FETCH cycle of the last one.
    task automatic run_n(input logic [7:0] instr, input int n, input int gap);
        int seen, last;
        seen = 0;
        last = 0;
        for (int k = 0; k < n; k++) push_instr(instr);
        @(posedge clk50); #1;
        instruction = instr;
        run         = 1'b1;
        for (int i = 0; i < n * gap + 20 && seen < n; i++) begin
            @(negedge clk50);
            if (state == c_ST_FETCH) begin
                seen++;
                if (seen > 1) check_eq("tick_gap", cyc - last, gap);
                last = cyc;
                if (seen == n) run = 1'b0;
            end
        end
        run = 1'b0;
        check_eq("run_started", seen, n);
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        step        = 1'b0;
        instruction = 8'h49;
        repeat (3) @(posedge clk50);
        #1;
        check_eq("reset_state", {29'd0, state}, 32'd0);
        check_eq("reset_enables", {ir_write, pc_write, pc_src, alu_src,
                                   mem_read, mem_write, reg_write, reg_dst}, 32'd0);
        reset = 1'b0;
        @(posedge clk50); #1;
        check_eq("post_reset_state", {29'd0, state}, 32'd0);
        check_eq("post_reset_halted", halted, 1);
        check_eq("post_reset_count", instr_count, 0);
        mon_en = 1'b1;
        repeat (20) @(posedge clk50);

        // Free-run ADDs: one start per tick the controller is idle for.
        run_n(8'h06, 3, 8);
        wait_retired(8'd3, 40);

        // Single-step LW twice.
        push_instr(8'h49);
        step_instr(8'h49);
        wait_retired(8'd4, 40);
        repeat (6) @(posedge clk50);
        push_instr(8'h49);
        step_instr(8'h49);
        wait_retired(8'd5, 40);

        // Single-step SW then J.
        push_instr(8'hA9);
        step_instr(8'hA9);
        wait_retired(8'd6, 40);
        push_instr(8'hC1);
        step_instr(8'hC1);
        wait_retired(8'd7, 40);

        // LW with the ROM changing mid-flight and a second step while busy.
        push_instr(8'h49);
        push_instr(8'h06);
        step_instr(8'h49);
        wait_state(c_ST_DECODE, 20);
        instruction = 8'h06;
        @(posedge clk50); #1;
        step = 1'b1;
        @(posedge clk50); #1;
        step = 1'b0;
        wait_retired(8'd9, 60);
        repeat (12) @(posedge clk50);

        // Asynchronous reset in the MEM cycle of an LW.
        push_instr(8'h49);
        step_instr(8'h49);
        wait_state(c_ST_MEM, 20);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_state", {29'd0, state}, 32'd0);
        check_eq("async_enables", {ir_write, pc_write, pc_src, alu_src,
                                   mem_read, mem_write, reg_write, reg_dst}, 32'd0);
        check_eq("async_count", instr_count, 0);
        mon_en   = 1'b0;
        exp_q.delete();
        cnt_q.delete();
        exp_cnt  = 8'd0;
        was_busy = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Counter wrap: 255 jumps, then one more.
        run_n(8'hC1, 255, 4);
        wait_retired(8'd255, 40);
        check_eq("count_255", instr_count, 255);
        run_n(8'hC1, 1, 4);
        wait_retired(8'd0, 40);
        check_eq("count_wrap", instr_count, 0);
        repeat (10) @(posedge clk50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
